regfile_dump_reader: RTL and testbench

- Debug and readout engine that walks the architectural register file over an address range and streams each register's value on a valid/ready interface.
- It drives one register-file read address and samples the matching combinational read data.
- It sits beside the core's register file, using a spare read port (A2/RD2 muxed in debug mode, or a dedicated third port).
- It never writes the register file.

---
 rtl/regfile_dump_reader.sv | 102 ++++++++++
 tb/tb_regfile_dump_reader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// Register-file dump engine: walks START_REG..END_REG through one read port
// and streams each captured value on a valid/ready beat interface.
module regfile_dump_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned START_REG  = 0,
    parameter int unsigned END_REG    = 31
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    input  logic [DATA_WIDTH-1:0] rf_data,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [ADDR_WIDTH-1:0] dump_addr,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  dump_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] StartAddr = ADDR_WIDTH'(START_REG);
    localparam logic [ADDR_WIDTH-1:0] EndAddr   = ADDR_WIDTH'(END_REG);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StSend
    } state_e;

    state_e                state;
    logic [ADDR_WIDTH-1:0] cnt;

    assign rf_addr = cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= StIdle;
            cnt        <= StartAddr;
            dump_addr  <= '0;
            dump_data  <= '0;
            dump_last  <= 1'b0;
            dump_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        cnt   <= StartAddr;
                        busy  <= 1'b1;
                        state <= StFetch;
                    end
                end
                StFetch: begin
                    if (abort) begin
                        cnt   <= StartAddr;
                        busy  <= 1'b0;
                        state <= StIdle;
                    end else begin
                        // rf_data is the file's contents before this edge's write lands.
                        dump_data  <= rf_data;
                        dump_addr  <= cnt;
                        dump_last  <= (cnt == EndAddr);
                        dump_valid <= 1'b1;
                        state      <= StSend;
                    end
                end
                StSend: begin
                    if (abort) begin
                        // Abort beats a simultaneous acceptance; the beat is discarded.
                        cnt        <= StartAddr;
                        dump_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= StIdle;
                    end else if (dump_ready) begin
                        dump_valid <= 1'b0;
                        if (dump_last) begin
                            cnt   <= StartAddr;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= StIdle;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= StFetch;
                        end
                    end
                end
                default: begin
                    cnt        <= StartAddr;
                    dump_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: table-driven dump scenarios against a queue-free
// beat model, plus hand sequences for coherency, reset, idle controls and a 1-beat range.
module tb_regfile_dump_reader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start, abort, dump_ready;
    logic [4:0]  rf_addr, dump_addr;
    logic [31:0] rf_data, dump_data;
    logic        dump_valid, dump_last, busy, done;

    logic        start1, abort1, dump_ready1;
    logic [4:0]  rf_addr1, dump_addr1;
    logic [31:0] rf_data1, dump_data1;
    logic        dump_valid1, dump_last1, busy1, done1;

    logic [31:0] regs [32];

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    assign rf_data  = regs[rf_addr];
    assign rf_data1 = regs[rf_addr1];

    regfile_dump_reader #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .START_REG(0), .END_REG(31)
    ) u_dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .rf_addr(rf_addr), .rf_data(rf_data), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
        .dump_last(dump_last), .busy(busy), .done(done)
    );

    regfile_dump_reader #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .START_REG(10), .END_REG(10)
    ) u_dut_one (
        .clock(clock), .reset(reset), .start(start1), .abort(abort1),
        .rf_addr(rf_addr1), .rf_data(rf_data1), .dump_valid(dump_valid1),
        .dump_ready(dump_ready1), .dump_addr(dump_addr1), .dump_data(dump_data1),
        .dump_last(dump_last1), .busy(busy1), .done(done1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        int pct;       // dump_ready duty in percent
        int abort_at;  // beat index to abort on (-1 none)
        int busy_at;   // cycle to pulse start while busy (-1 none)
        bit rand_data;
        int exp_beats;
        bit exp_done;
        int exp_done_t; // -1 don't care
    } vec_t;

    // Runs one dump from IDLE; returns at the first cycle done is seen or after abort.
    task automatic run_dump(input int pct, input int abort_at, input int busy_at,
                            output int beats, output bit got_done,
                            output int done_t, output int first_t);
        logic [31:0] exp_mem [32];
        bit          hold, aborted;
        logic [4:0]  h_addr;
        logic [31:0] h_data;
        logic        h_last;
        for (int i = 0; i < 32; i++) exp_mem[i] = regs[i];
        beats = 0; got_done = 0; done_t = -1; first_t = -1;
        hold = 0; aborted = 0; h_addr = '0; h_data = '0; h_last = 1'b0;
        start = 1'b1; abort = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clock);
            start = 1'b0;
            abort = 1'b0;
            if (aborted) begin
                check("abort valid", 64'(dump_valid), 64'd0);
                check("abort busy", 64'(busy), 64'd0);
                check("abort done", 64'(done), 64'd0);
                check("abort rf_addr", 64'(rf_addr), 64'd0);
                return;
            end
            if (done) begin
                got_done = 1;
                done_t = t;
                check("busy after done", 64'(busy), 64'd0);
                return;
            end
            if (t == busy_at) begin
                check("busy at start-while-busy", 64'(busy), 64'd1);
                start = 1'b1;
            end
            if (dump_valid) begin
                if (first_t < 0) first_t = t;
                if (hold) begin
                    check("hold addr", 64'(dump_addr), 64'(h_addr));
                    check("hold data", 64'(dump_data), 64'(h_data));
                    check("hold last", 64'(dump_last), 64'(h_last));
                end else begin
                    check("beat addr", 64'(dump_addr), 64'(beats));
                    check("beat data", 64'(dump_data), 64'(exp_mem[beats]));
                    check("beat last", 64'(dump_last), 64'(beats == 31));
                end
                dump_ready = ($urandom_range(0, 99) < pct);
                if (beats == abort_at) begin
                    dump_ready = 1'b1;
                    abort = 1'b1;
                    aborted = 1;
                end
                hold = !dump_ready;
                h_addr = dump_addr; h_data = dump_data; h_last = dump_last;
                if (dump_ready && !abort) beats++;
            end else begin
                hold = 0;
                dump_ready = ($urandom_range(0, 99) < pct);
            end
        end
        check("dump timeout", 64'd1, 64'd0);
    endtask

    vec_t vecs [6];

    initial begin
        int beats, done_t, first_t, seen;
        bit got_done;
        bit ok;

        vecs[0] = '{100, -1, -1, 0, 32, 1, 64};
        vecs[1] = '{30,  -1, -1, 1, 32, 1, -1};
        vecs[2] = '{100,  7, -1, 1,  7, 0, -1};
        vecs[3] = '{100, -1, 10, 1, 32, 1, 64};
        vecs[4] = '{50,   0, -1, 1,  0, 0, -1};
        vecs[5] = '{30,  31, -1, 1, 31, 0, -1};

        for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i;
        reset = 1'b1; start = 1'b0; abort = 1'b0; dump_ready = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; dump_ready1 = 1'b0;
        repeat (2) @(negedge clock);
        check("rst rf_addr", 64'(rf_addr), 64'd0);
        check("rst dump_addr", 64'(dump_addr), 64'd0);
        check("rst dump_data", 64'(dump_data), 64'd0);
        check("rst valid", 64'(dump_valid), 64'd0);
        check("rst last", 64'(dump_last), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst rf_addr one", 64'(rf_addr1), 64'd10);
        reset = 1'b0;
        @(negedge clock);

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].rand_data) for (int i = 0; i < 32; i++) regs[i] = $urandom;
            run_dump(vecs[v].pct, vecs[v].abort_at, vecs[v].busy_at,
                     beats, got_done, done_t, first_t);
            check($sformatf("vec%0d beats", v), 64'(beats), 64'(vecs[v].exp_beats));
            check($sformatf("vec%0d done", v), 64'(got_done), 64'(vecs[v].exp_done));
            if (vecs[v].exp_done_t >= 0) begin
                check($sformatf("vec%0d done cycle", v), 64'(done_t), 64'(vecs[v].exp_done_t));
                check($sformatf("vec%0d first valid", v), 64'(first_t), 64'd1);
            end
        end
        @(negedge clock);
        dump_ready = 1'b0;

        // Coherency: late write to x4 invisible, early write to x6 visible.
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i;
        start = 1'b1;
        ok = 0;
        for (int t = 0; t < 400 && !ok; t++) begin
            @(negedge clock);
            start = 1'b0;
            dump_ready = 1'b0;
            if (done) ok = 1;
            else if (dump_valid) begin
                if (dump_addr == 5'd4) begin
                    regs[4] = 32'h0000_1234;
                    @(negedge clock);
                    check("coh x4 old", 64'(dump_data), 64'h1000_0004);
                end
                if (dump_addr == 5'd5) regs[6] = 32'hDEAD_BEEF;
                if (dump_addr == 5'd6) check("coh x6 new", 64'(dump_data), 64'hDEAD_BEEF);
                dump_ready = 1'b1;
            end
        end
        check("coh completes", 64'(ok), 64'd1);
        dump_ready = 1'b0;

        // Reset during SEND of x3.
        start = 1'b1;
        ok = 0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clock);
            start = 1'b0;
            dump_ready = dump_valid && (dump_addr < 5'd3);
            if (dump_valid && dump_addr == 5'd3) begin
                reset = 1'b1;
                ok = 1;
            end
        end
        check("reached x3", 64'(ok), 64'd1);
        @(negedge clock);
        reset = 1'b0;
        dump_ready = 1'b0;
        check("midrst valid", 64'(dump_valid), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst addr", 64'(dump_addr), 64'd0);
        check("midrst data", 64'(dump_data), 64'd0);
        check("midrst last", 64'(dump_last), 64'd0);
        check("midrst rf_addr", 64'(rf_addr), 64'd0);
        check("midrst done", 64'(done), 64'd0);

        // Idle controls: abort alone ignored, start+abort starts.
        abort = 1'b1;
        @(negedge clock);
        check("idle abort busy", 64'(busy), 64'd0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0; abort = 1'b0;
        check("start wins busy", 64'(busy), 64'd1);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("fetch abort busy", 64'(busy), 64'd0);

        // Single-register range.
        start1 = 1'b1;
        seen = 0;
        done_t = -1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clock);
            start1 = 1'b0;
            dump_ready1 = 1'b1;
            if (dump_valid1) begin
                seen++;
                check("one addr", 64'(dump_addr1), 64'd10);
                check("one data", 64'(dump_data1), 64'(regs[10]));
                check("one last", 64'(dump_last1), 64'd1);
                check("one valid cycle", 64'(t), 64'd1);
            end
            if (done1) begin
                if (done_t < 0) done_t = t;
                else check("one done pulse width", 64'(t), 64'(done_t));
            end
        end
        check("one beats", 64'(seen), 64'd1);
        check("one done cycle", 64'(done_t), 64'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
